// File: rtl/csi2_1lane_pkt_rx.sv
// CSI-2 single-lane packet receiver.
// Finds the HS sync byte, parses the 4-byte packet header, forwards the
// long-packet payload one cycle after acceptance, and checks the payload
// CRC-16. It also flags bursts that end mid-packet and tracks the
// frame-start/frame-end state.
module csi2_1lane_pkt_rx #(
  parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        hs_active_i,
  input  logic [7:0]  byte_i,
  input  logic        byte_en_i,
  output logic        hdr_valid_o,
  output logic [1:0]  vc_o,
  output logic [5:0]  dt_o,
  output logic [15:0] wc_o,
  output logic [7:0]  ecc_o,
  output logic [7:0]  pix_data_o,
  output logic        pix_valid_o,
  output logic        pkt_end_o,
  output logic        crc_err_o,
  output logic        trunc_err_o,
  output logic        fs_o,
  output logic        fe_o,
  output logic        frame_active_o
);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CRC, WAIT_END} state_t;

  state_t      state, state_nxt;
  logic        acc;          // byte accepted this cycle
  logic [1:0]  hdr_idx;
  logic [7:0]  di_q, wc_lo_q, wc_hi_q, crc_lo_q;
  logic [15:0] cnt_q, crc_q;
  logic        crc_idx_q;
  logic        hdr_done, pay_beat, crc_done, trunc, is_short;

  assign acc      = byte_en_i & hs_active_i;
  assign is_short = (di_q[5:0] <= 6'h0F);

  // One byte through the reflected CRC-16 (poly 0x1021 reversed = 0x8408), LSB first.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 0; i < 8; i++) begin
      fb = r[0] ^ d[i];
      r  = {1'b0, r[15:1]} ^ (fb ? 16'h8408 : 16'h0000);
    end
    return r;
  endfunction

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    // NOTE: a default first on every always_comb target keeps synthesis from inferring latches.
    state_nxt = state;
    case (state)
      IDLE:     if (acc && byte_i == SYNC_BYTE) state_nxt = HDR;
      HDR: begin
        if (trunc) state_nxt = IDLE;
        else if (hdr_done) begin
          if (is_short)                     state_nxt = WAIT_END;
          else if ({wc_hi_q, wc_lo_q} != '0) state_nxt = PAYLOAD;
          else                              state_nxt = CRC;
        end
      end
      PAYLOAD: begin
        if (trunc)                          state_nxt = IDLE;
        else if (pay_beat && cnt_q == 16'd1) state_nxt = CRC;
      end
      CRC: begin
        if (trunc)         state_nxt = IDLE;
        else if (crc_done) state_nxt = WAIT_END;
      end
      WAIT_END: if (!hs_active_i) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Per-state event decode that drives the registered outputs and datapath.
  always_comb begin
    hdr_done = 1'b0;
    pay_beat = 1'b0;
    crc_done = 1'b0;
    trunc    = 1'b0;
    case (state)
      HDR: begin
        hdr_done = acc && (hdr_idx == 2'd3);
        trunc    = !hs_active_i;
      end
      PAYLOAD: begin
        pay_beat = acc;
        trunc    = !hs_active_i;
      end
      CRC: begin
        crc_done = acc && crc_idx_q;
        trunc    = !hs_active_i;
      end
      default: ;
    endcase
  end

  // Header capture, payload count, CRC accumulation and registered output pulses.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hdr_idx        <= '0;
      di_q           <= '0;
      wc_lo_q        <= '0;
      wc_hi_q        <= '0;
      crc_lo_q       <= '0;
      cnt_q          <= '0;
      crc_q          <= '0;
      crc_idx_q      <= 1'b0;
      hdr_valid_o    <= 1'b0;
      vc_o           <= '0;
      dt_o           <= '0;
      wc_o           <= '0;
      ecc_o          <= '0;
      pix_data_o     <= '0;
      pix_valid_o    <= 1'b0;
      pkt_end_o      <= 1'b0;
      crc_err_o      <= 1'b0;
      trunc_err_o    <= 1'b0;
      fs_o           <= 1'b0;
      fe_o           <= 1'b0;
      frame_active_o <= 1'b0;
    end else begin
      hdr_valid_o <= hdr_done;
      fs_o        <= hdr_done && (di_q[5:0] == 6'h00);
      fe_o        <= hdr_done && (di_q[5:0] == 6'h01);
      pix_valid_o <= pay_beat;
      pkt_end_o   <= crc_done;
      crc_err_o   <= crc_done && ({byte_i, crc_lo_q} != crc_q);
      trunc_err_o <= trunc;

      if (state == IDLE) hdr_idx <= '0;

      if (state == HDR && acc) begin
        case (hdr_idx)
          2'd0:    di_q    <= byte_i;
          2'd1:    wc_lo_q <= byte_i;
          2'd2:    wc_hi_q <= byte_i;
          default: ;
        endcase
        hdr_idx <= hdr_idx + 2'd1;
      end

      if (hdr_done) begin
        vc_o      <= di_q[7:6];
        dt_o      <= di_q[5:0];
        wc_o      <= {wc_hi_q, wc_lo_q};
        ecc_o     <= byte_i;
        cnt_q     <= {wc_hi_q, wc_lo_q};
        crc_q     <= 16'hFFFF;
        crc_idx_q <= 1'b0;
        if (di_q[5:0] == 6'h00) frame_active_o <= 1'b1;
        if (di_q[5:0] == 6'h01) frame_active_o <= 1'b0;
      end

      if (pay_beat) begin
        pix_data_o <= byte_i;
        cnt_q      <= cnt_q - 16'd1;
        crc_q      <= crc16_byte(crc_q, byte_i);
      end

      if (state == CRC && acc && !crc_idx_q) begin
        crc_lo_q  <= byte_i;
        crc_idx_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csi2_1lane_pkt_rx.sv
// Scoreboard bench for csi2_1lane_pkt_rx: the drivers push expected headers,
// pixels and packet ends; a negedge monitor pops and compares them.
module tb_csi2_1lane_pkt_rx;

  localparam logic [7:0] SYNC = 8'hB8;

  logic        clk_i = 1'b0;
  logic        reset_i, hs_active_i, byte_en_i;
  logic [7:0]  byte_i;
  logic        hdr_valid_o, pix_valid_o, pkt_end_o, crc_err_o, trunc_err_o;
  logic        fs_o, fe_o, frame_active_o;
  logic [1:0]  vc_o;
  logic [5:0]  dt_o;
  logic [15:0] wc_o;
  logic [7:0]  ecc_o, pix_data_o;

  csi2_1lane_pkt_rx #(.SYNC_BYTE(SYNC)) dut (
    .clk_i(clk_i), .reset_i(reset_i), .hs_active_i(hs_active_i),
    .byte_i(byte_i), .byte_en_i(byte_en_i),
    .hdr_valid_o(hdr_valid_o), .vc_o(vc_o), .dt_o(dt_o), .wc_o(wc_o), .ecc_o(ecc_o),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .pkt_end_o(pkt_end_o),
    .crc_err_o(crc_err_o), .trunc_err_o(trunc_err_o),
    .fs_o(fs_o), .fe_o(fe_o), .frame_active_o(frame_active_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct { logic [7:0] data; int cyc; } pix_t;
  typedef struct { logic [1:0] vc; logic [5:0] dt; logic [15:0] wc; logic [7:0] ecc;
                   logic fs; logic fe; logic fa; } hdr_t;

  pix_t       pix_q[$];
  hdr_t       hdr_q[$];
  bit         end_q[$];
  logic [7:0] pay[$];
  logic [7:0] p24 [24] = '{8'hFF, 8'h00, 8'h00, 8'h02, 8'hB9, 8'hDC, 8'hF3, 8'h72,
                           8'hBB, 8'hD4, 8'hB8, 8'h5A, 8'hC8, 8'h75, 8'hC2, 8'h7C,
                           8'h81, 8'hF8, 8'h05, 8'hDF, 8'hFF, 8'h00, 8'h00, 8'h01};

  int n_cmp = 0, n_bad = 0, cyc = 0, trunc_cnt = 0, exp_trunc = 0;
  bit fa_model = 1'b0;
  bit gap_en   = 1'b0;
  pix_t pe;
  hdr_t he;
  bit   ee;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) cyc <= cyc + 1;

  // Monitor: every output pulse must match the oldest pending expectation.
  always @(negedge clk_i) begin
    if (pix_valid_o) begin
      if (pix_q.size() == 0) check("pix_extra", 64'(pix_valid_o), 64'd0);
      else begin
        pe = pix_q.pop_front();
        check("pix_data", 64'(pix_data_o), 64'(pe.data));
        check("pix_lat", 64'(cyc), 64'(pe.cyc));
      end
    end
    if (hdr_valid_o) begin
      if (hdr_q.size() == 0) check("hdr_extra", 64'(hdr_valid_o), 64'd0);
      else begin
        he = hdr_q.pop_front();
        check("hdr_vc", 64'(vc_o), 64'(he.vc));
        check("hdr_dt", 64'(dt_o), 64'(he.dt));
        check("hdr_wc", 64'(wc_o), 64'(he.wc));
        check("hdr_ecc", 64'(ecc_o), 64'(he.ecc));
        check("hdr_fs_fe", 64'({fs_o, fe_o}), 64'({he.fs, he.fe}));
        check("hdr_frame_active", 64'(frame_active_o), 64'(he.fa));
      end
    end else if (fs_o || fe_o) check("fs_fe_stray", 64'({fs_o, fe_o}), 64'd0);
    if (pkt_end_o) begin
      if (end_q.size() == 0) check("pkt_end_extra", 64'(pkt_end_o), 64'd0);
      else begin
        ee = end_q.pop_front();
        check("crc_err", 64'(crc_err_o), 64'(ee));
      end
    end else if (crc_err_o) check("crc_err_stray", 64'(crc_err_o), 64'd0);
    if (trunc_err_o) trunc_cnt++;
  end

  // Drive one accepted byte, optionally preceded by random disabled cycles.
  task automatic put(input logic [7:0] b, input bit is_pix);
    int   g;
    pix_t e;
    g = gap_en ? int'($urandom_range(0, 2)) : 0;
    repeat (g) begin
      @(posedge clk_i); #1;
      byte_en_i = 1'b0; byte_i = 8'($urandom); hs_active_i = 1'b1;
    end
    @(posedge clk_i); #1;
    byte_i = b; byte_en_i = 1'b1; hs_active_i = 1'b1;
    if (is_pix) begin
      e.data = b;
      e.cyc  = cyc + 1;
      pix_q.push_back(e);
    end
  endtask

  // Drop HS; a byte_en with a sync value in that cycle must be ignored.
  task automatic end_burst();
    @(posedge clk_i); #1;
    hs_active_i = 1'b0; byte_en_i = 1'b1; byte_i = SYNC;
    @(posedge clk_i); #1;
    byte_en_i = 1'b0;
    repeat (2) @(posedge clk_i);
  endtask

  task automatic hdr(input logic [7:0] di, input logic [15:0] wc, input logic [7:0] ecc);
    hdr_t h;
    put(SYNC, 1'b0);
    put(di, 1'b0);
    put(wc[7:0], 1'b0);
    put(wc[15:8], 1'b0);
    if (di[5:0] == 6'h00) fa_model = 1'b1;
    else if (di[5:0] == 6'h01) fa_model = 1'b0;
    h.vc = di[7:6]; h.dt = di[5:0]; h.wc = wc; h.ecc = ecc;
    h.fs = (di[5:0] == 6'h00); h.fe = (di[5:0] == 6'h01); h.fa = fa_model;
    hdr_q.push_back(h);
    put(ecc, 1'b0);
  endtask

  task automatic long_pkt(input logic [7:0] di, input logic [7:0] c0, input logic [7:0] c1,
                          input bit exp_err);
    hdr(di, 16'(pay.size()), 8'h5A);
    foreach (pay[i]) put(pay[i], 1'b1);
    put(c0, 1'b0);
    end_q.push_back(exp_err);
    put(c1, 1'b0);
    put(SYNC, 1'b0);   // trailer bytes, ignored
    put(8'h01, 1'b0);
    end_burst();
  endtask

  task automatic load_p24();
    pay.delete();
    for (int i = 0; i < 24; i++) pay.push_back(p24[i]);
  endtask

  task automatic settle(input string tag);
    repeat (6) @(posedge clk_i);
    #1;
    check({tag, "_trunc"}, 64'(trunc_cnt), 64'(exp_trunc));
    check({tag, "_pending"}, 64'(pix_q.size() + hdr_q.size() + end_q.size()), 64'd0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({hdr_valid_o, vc_o, dt_o, wc_o, ecc_o, pix_data_o, pix_valid_o, pkt_end_o,
                crc_err_o, trunc_err_o, fs_o, fe_o, frame_active_o});
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (got timeout, expected finish)");
    $fatal(1);
  end

  initial begin
    reset_i = 1'b1; hs_active_i = 1'b0; byte_en_i = 1'b0; byte_i = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_outs", all_outs(), 64'd0);
    reset_i = 1'b0;

    // Frame start, preceded by a non-sync byte in IDLE.
    put(8'h12, 1'b0);
    hdr(8'h00, 16'h0000, 8'h11);
    end_burst();
    settle("fs");
    check("fa_after_fs", 64'(frame_active_o), 64'd1);

    gap_en = 1'b1;
    load_p24();
    long_pkt(8'h6A, 8'hF0, 8'h00, 1'b0);
    settle("long_good");
    load_p24();
    long_pkt(8'h2A, 8'hF1, 8'h00, 1'b1);
    settle("long_bad");

    // Truncated payload: WC=100, only 40 bytes before HS drops.
    pay.delete();
    hdr(8'h2A, 16'd100, 8'h33);
    for (int i = 0; i < 40; i++) put(8'($urandom), 1'b1);
    exp_trunc++;
    end_burst();
    settle("trunc_pay");
    check("fa_after_trunc", 64'(frame_active_o), 64'd1);

    // Truncated inside the header.
    put(SYNC, 1'b0);
    put(8'h2A, 1'b0);
    exp_trunc++;
    end_burst();
    settle("trunc_hdr");

    pay.delete();
    long_pkt(8'h2A, 8'hFF, 8'hFF, 1'b0);
    settle("wc_zero");

    hdr(8'h00, 16'h0007, 8'h22);
    end_burst();
    settle("fs_again");
    hdr(8'h01, 16'h0007, 8'h44);
    end_burst();
    settle("fe");
    check("fa_after_fe", 64'(frame_active_o), 64'd0);

    // Reset in the middle of a payload, then carry on in the same burst.
    hdr(8'h2B, 16'd50, 8'h77);
    for (int i = 0; i < 10; i++) put(8'(8'h10 + i), 1'b1);
    @(posedge clk_i); #1;
    byte_en_i = 1'b0;
    @(negedge clk_i); #2;
    check("pre_rst_wc", 64'(wc_o), 64'd50);
    reset_i = 1'b1;
    #1;
    check("mid_reset_outs", all_outs(), 64'd0);
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    hdr(8'h08, 16'h1234, 8'h9C);
    end_burst();
    settle("after_reset");

    load_p24();
    long_pkt(8'hAA, 8'hF0, 8'h00, 1'b0);
    settle("final_long");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
